compute_cluster: RTL and testbench

//  Parametrised cluster of NUM_UNITS compute lanes sharing one instruction port and one result port.

---
 rtl/compute_cluster_pkg.sv | 52 +++++
 rtl/compute_cluster_lane.sv | 47 ++++
 rtl/compute_cluster.sv | 173 +++++++++++++++++
 tb/tb_compute_cluster.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/compute_cluster_pkg.sv
// Shared opcodes, instruction field positions and FSM encodings for compute_cluster.
package compute_cluster_pkg;

    localparam int OP_HI   = 15;
    localparam int OP_LO   = 13;
    localparam int UNIT_HI = 12;
    localparam int UNIT_LO = 11;
    localparam int RD_HI   = 10;
    localparam int RD_LO   = 9;
    localparam int RS1_HI  = 8;
    localparam int RS1_LO  = 7;
    localparam int RS2_HI  = 6;
    localparam int RS2_LO  = 5;
    localparam int IMM_HI  = 7;
    localparam int IMM_LO  = 0;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_RD  = 3'b110;
    localparam logic [2:0] OP_RED = 3'b111;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXEC   = 2'd1;
    localparam logic [1:0] S_REDUCE = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] unit;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic [7:0] imm;
    } instr_t;

    // imm overlaps rs1/rs2 in the raw word; only LDI looks at it.
    function automatic instr_t decode(input logic [15:0] w);
        instr_t r;
        r.op   = w[OP_HI:OP_LO];
        r.unit = w[UNIT_HI:UNIT_LO];
        r.rd   = w[RD_HI:RD_LO];
        r.rs1  = w[RS1_HI:RS1_LO];
        r.rs2  = w[RS2_HI:RS2_LO];
        r.imm  = w[IMM_HI:IMM_LO];
        return r;
    endfunction

endpackage

// File: rtl/compute_cluster_lane.sv
// One compute lane: 4-entry register file plus combinational ALU.
module compute_lane
    import compute_cluster_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [2:0]        op_i,
    input  logic [1:0]        rd_i,
    input  logic [1:0]        rs1_i,
    input  logic [1:0]        rs2_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [DATA_W-1:0] rs1_data_o
);

    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] res_d;

    assign a          = regs_q[rs1_i];
    assign b          = regs_q[rs2_i];
    assign rs1_data_o = a;

    always_comb begin
        res_d = '0;
        case (op_i)
            OP_LDI:  res_d = imm_i;
            OP_ADD:  res_d = a + b;
            OP_SUB:  res_d = a - b;
            OP_AND:  res_d = a & b;
            OP_OR:   res_d = a | b;
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[rd_i] <= res_d;
        end
    end

endmodule

// File: rtl/compute_cluster.sv
// Lane cluster with shared instruction/result handshakes and a central FSM.
// Define CLUSTER_REDUCE_EN to build the RED (XOR-reduce across lanes) op.
module compute_cluster
    import compute_cluster_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_unit,
    output logic              err
);

    logic [1:0]        state_q, state_d;
    logic [15:0]       instr_q;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [1:0]        out_unit_q, out_unit_d;
    logic              err_q, err_d;

    instr_t            ins;
    logic              unit_ok;
    logic              op_ok;
    logic              legal;
    logic              is_alu;
    logic              exec_wr;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] rs1_data [NUM_UNITS];

    assign ins     = decode(instr_q);
    assign unit_ok = int'(ins.unit) < NUM_UNITS;
`ifdef CLUSTER_REDUCE_EN
    assign op_ok   = 1'b1;
`else
    assign op_ok   = ins.op != OP_RED;
`endif
    assign legal   = unit_ok && op_ok;
    assign is_alu  = (ins.op >= OP_LDI) && (ins.op <= OP_OR);
    assign exec_wr = (state_q == S_EXEC) && legal && is_alu;

    assign in_ready  = rst_n && ena && (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_unit  = out_unit_q;
    assign err       = err_q;

    for (genvar k = 0; k < NUM_UNITS; k++) begin : g_lane
        logic we;
        assign we = exec_wr && (ins.unit == 2'(k));
        compute_lane #(.DATA_W(DATA_W)) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .we_i       (we),
            .op_i       (ins.op),
            .rd_i       (ins.rd),
            .rs1_i      (ins.rs1),
            .rs2_i      (ins.rs2),
            .imm_i      (ins.imm[DATA_W-1:0]),
            .rs1_data_o (rs1_data[k])
        );
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (ins.unit == 2'(k)) sel_data = rs1_data[k];
        end
    end

`ifdef CLUSTER_REDUCE_EN
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] red_data;

    always_comb begin
        red_data = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (cnt_q == 2'(k)) red_data = rs1_data[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_unit_d  = out_unit_q;
        err_d       = err_q;
`ifdef CLUSTER_REDUCE_EN
        cnt_d       = cnt_q;
        acc_d       = acc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_IDLE;
                if (!legal) begin
                    err_d = 1'b1;
                end else if (ins.op == OP_RD) begin
                    out_data_d  = sel_data;
                    out_unit_d  = ins.unit;
                    out_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
`ifdef CLUSTER_REDUCE_EN
                else if (ins.op == OP_RED) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_REDUCE;
                end
`endif
            end
`ifdef CLUSTER_REDUCE_EN
            S_REDUCE: begin
                acc_d = acc_q ^ red_data;
                cnt_d = cnt_q + 2'd1;
                if (int'(cnt_q) == NUM_UNITS - 1) begin
                    out_data_d  = acc_q ^ red_data;
                    out_unit_d  = '0;
                    out_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
`endif
            S_RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            instr_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_unit_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_unit_q  <= out_unit_d;
            err_q       <= err_d;
            if (in_valid && in_ready) instr_q <= in_instr;
        end
    end

endmodule

// File: tb/tb_compute_cluster.sv
// Directed bench for compute_cluster: a 4-lane instance and a 2-lane instance.
module tb_compute_cluster;

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic [1:0]       in_valid;
    logic [1:0]       in_ready;
    logic [1:0][15:0] in_instr;
    logic [1:0]       out_valid;
    logic [1:0]       out_ready;
    logic [1:0][7:0]  out_data;
    logic [1:0][1:0]  out_unit;
    logic [1:0]       err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] ins;
        bit          has_out;
        logic [7:0]  d;
        logic [1:0]  u;
    } vec_t;

    vec_t vq[$];

    compute_cluster #(.NUM_UNITS(4), .DATA_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_instr(in_instr[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_unit(out_unit[0]), .err(err[0])
    );

    compute_cluster #(.NUM_UNITS(2), .DATA_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_instr(in_instr[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_unit(out_unit[1]), .err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] u,
                                       input logic [1:0] d, input logic [1:0] s1,
                                       input logic [1:0] s2);
        return {op, u, d, s1, s2, 5'b0};
    endfunction

    function automatic logic [15:0] ldi(input logic [1:0] u, input logic [1:0] d,
                                        input logic [7:0] imm);
        return {3'b001, u, d, 1'b0, imm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance (EXEC cycle).
    task automatic issue(input int d, input logic [15:0] ins);
        int n = 0;
        while (!in_ready[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[d]) chk("issue_timeout", 32'(in_ready[d]), 32'd1);
        in_instr[d] = ins;
        in_valid[d] = 1'b1;
        @(negedge clk);
        in_valid[d] = 1'b0;
    endtask

    task automatic get_out(input int d, input logic [7:0] ed, input logic [1:0] eu,
                           input int elat, input string nm);
        int n = 0;
        while (!out_valid[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, 32'(out_valid[d]), 32'd1);
        chk({nm, "_lat"}, 32'(n), 32'(elat));
        chk({nm, "_data"}, 32'(out_data[d]), 32'(ed));
        chk({nm, "_unit"}, 32'(out_unit[d]), 32'(eu));
        @(negedge clk);
    endtask

    initial begin
        int  n;
        bit  seen;
        rst_n     = 1'b0;
        ena       = 1'b1;
        in_valid  = '0;
        in_instr  = '0;
        out_ready = 2'b11;

        vq.push_back('{mk(3'b110, 0, 0, 0, 0), 1, 8'h00, 2'd0});
        vq.push_back('{ldi(1, 2, 8'hF0),         0, 8'h00, 2'd0});
        vq.push_back('{ldi(1, 3, 8'h20),         0, 8'h00, 2'd0});
        vq.push_back('{mk(3'b010, 1, 1, 2, 3), 0, 8'h00, 2'd0});
        vq.push_back('{mk(3'b110, 1, 0, 1, 0), 1, 8'h10, 2'd1});
        vq.push_back('{mk(3'b011, 1, 0, 3, 2), 0, 8'h00, 2'd0});
        vq.push_back('{mk(3'b110, 1, 0, 0, 0), 1, 8'h30, 2'd1});
        vq.push_back('{mk(3'b100, 1, 3, 2, 1), 0, 8'h00, 2'd0});
        vq.push_back('{mk(3'b110, 1, 0, 3, 0), 1, 8'h10, 2'd1});
        vq.push_back('{ldi(2, 1, 8'h0C),         0, 8'h00, 2'd0});
        vq.push_back('{mk(3'b101, 2, 1, 1, 1), 0, 8'h00, 2'd0});
        vq.push_back('{mk(3'b010, 2, 1, 1, 1), 0, 8'h00, 2'd0});
        vq.push_back('{mk(3'b110, 2, 0, 1, 0), 1, 8'h18, 2'd2});
        vq.push_back('{ldi(3, 0, 8'h0F),         0, 8'h00, 2'd0});
        vq.push_back('{ldi(3, 1, 8'hA0),         0, 8'h00, 2'd0});
        vq.push_back('{mk(3'b101, 3, 2, 0, 1), 0, 8'h00, 2'd0});
        vq.push_back('{mk(3'b000, 0, 0, 0, 0), 0, 8'h00, 2'd0});
        vq.push_back('{mk(3'b110, 3, 0, 2, 0), 1, 8'hAF, 2'd3});
        vq.push_back('{mk(3'b011, 2, 2, 0, 1), 0, 8'h00, 2'd0});
        vq.push_back('{mk(3'b110, 2, 0, 2, 0), 1, 8'hE8, 2'd2});
        vq.push_back('{mk(3'b110, 2, 0, 0, 0), 1, 8'h00, 2'd2});

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready[0]), 32'd0);
        chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_out_data", 32'(out_data[0]), 32'd0);
        chk("rst_out_unit", 32'(out_unit[0]), 32'd0);
        chk("rst_err", 32'(err[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready[0]), 32'd1);

        foreach (vq[i]) begin
            issue(0, vq[i].ins);
            if (vq[i].has_out)
                get_out(0, vq[i].d, vq[i].u, 1, $sformatf("v%0d", i));
        end
        @(negedge clk);
        chk("table_err", 32'(err[0]), 32'd0);

        // Backpressure: result held while out_ready is low.
        out_ready[0] = 1'b0;
        issue(0, mk(3'b110, 1, 0, 1, 0));
        n = 0;
        while (!out_valid[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_valid%0d", c), 32'(out_valid[0]), 32'd1);
            chk($sformatf("bp_data%0d", c), 32'(out_data[0]), 32'h10);
            chk($sformatf("bp_ready%0d", c), 32'(in_ready[0]), 32'd0);
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_drop", 32'(out_valid[0]), 32'd0);
        chk("bp_in_ready", 32'(in_ready[0]), 32'd1);

        // ena low blocks acceptance; an in-flight op still completes.
        ena = 1'b0;
        in_instr[0] = ldi(0, 1, 8'h77);
        in_valid[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("ena_block", 32'(in_ready[0]), 32'd0);
        in_valid[0] = 1'b0;
        ena = 1'b1;
        issue(0, mk(3'b110, 2, 0, 1, 0));
        ena = 1'b0;
        get_out(0, 8'h18, 2'd2, 1, "ena_mid");
        chk("ena_mid_ready", 32'(in_ready[0]), 32'd0);
        ena = 1'b1;
        @(negedge clk);
        issue(0, mk(3'b110, 0, 0, 1, 0));
        get_out(0, 8'h00, 2'd0, 1, "ena_nowrite");

        // Out-of-range unit on the 2-lane instance.
        chk("u2_err0", 32'(err[1]), 32'd0);
        issue(1, ldi(3, 0, 8'h55));
        @(negedge clk);
        chk("u2_err1", 32'(err[1]), 32'd1);
        issue(1, mk(3'b110, 1, 0, 0, 0));
        get_out(1, 8'h00, 2'd1, 1, "u2_rd1");
        issue(1, mk(3'b110, 0, 0, 0, 0));
        get_out(1, 8'h00, 2'd0, 1, "u2_rd0");
        issue(1, ldi(1, 0, 8'h11));
        issue(1, mk(3'b110, 1, 0, 0, 0));
        get_out(1, 8'h11, 2'd1, 1, "u2_legal");
        chk("u2_err_sticky", 32'(err[1]), 32'd1);

`ifdef CLUSTER_REDUCE_EN
        issue(0, ldi(0, 0, 8'h0F));
        issue(0, ldi(1, 0, 8'hF0));
        issue(0, ldi(2, 0, 8'h33));
        issue(0, ldi(3, 0, 8'h00));
        issue(0, mk(3'b111, 0, 0, 0, 0));
        get_out(0, 8'hCC, 2'd0, 5, "red");
        chk("red_err", 32'(err[0]), 32'd0);
`else
        issue(0, mk(3'b111, 0, 0, 0, 0));
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid[0]) seen = 1'b1;
            @(negedge clk);
        end
        chk("red_no_out", 32'(seen), 32'd0);
        chk("red_err", 32'(err[0]), 32'd1);
`endif

        // Async reset while a result is pending.
        out_ready[0] = 1'b0;
        issue(0, mk(3'b110, 1, 0, 1, 0));
        n = 0;
        while (!out_valid[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rst_pre_valid", 32'(out_valid[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid[0]), 32'd0);
        chk("arst_data", 32'(out_data[0]), 32'd0);
        chk("arst_ready", 32'(in_ready[0]), 32'd0);
        chk("arst_err", 32'(err[0]), 32'd0);
        out_ready[0] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, mk(3'b110, 1, 0, 1, 0));
        get_out(0, 8'h00, 2'd1, 1, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
